// File: rtl/fft2d_bfly_sched_pkg.sv
// Shared definitions for the radix-2x2 2-D FFT butterfly scheduler:
// FSM encoding, latency defaults, datapath bus widths and a small sizing helper.
package fft2d_bfly_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  localparam int unsigned LOG2N_DEF  = 3;
  localparam int unsigned RD_LAT_DEF = 1;
  localparam int unsigned BF_LAT_DEF = 1;

  // Butterfly bus: four complex corners of SAMPLE_W-bit I/Q each.
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned IN_BUS_W  = 4 * 2 * SAMPLE_W;
  localparam int unsigned OUT_BUS_W = IN_BUS_W;

  // Bits needed to count 0..v, never less than one.
  function automatic int unsigned cnt_w(input int unsigned v);
    if (v < 32'd2) begin
      return 1;
    end else begin
      return $clog2(v + 32'd1);
    end
  endfunction

endpackage

// File: rtl/fft2d_bfly_sched_pair_addr.sv
// Row or column index generator: inserts a 0 at bit log2(h) of the quad
// counter (h = N >> (s+1)) to form the base index and its +h partner.
module fft2d_pair_addr #(
  parameter int unsigned LOG2N = 3,
  parameter int unsigned KW    = 2
) (
  input  logic [KW-1:0]    k,
  input  logic [LOG2N-1:0] s,
  output logic [LOG2N-1:0] base_idx,
  output logic [LOG2N-1:0] pair_idx
);

  localparam logic [LOG2N-1:0] ONE     = LOG2N'(1);
  localparam logic [LOG2N-1:0] TOP_POS = LOG2N'(LOG2N - 1);

  logic [LOG2N-1:0] kx_s;
  logic [LOG2N-1:0] h_s;
  logic [LOG2N-1:0] low_mask_s;

  // Split k around the butterfly span bit and open a zero gap there.
  always_comb begin
    kx_s       = LOG2N'(k);
    h_s        = ONE << (TOP_POS - s);
    low_mask_s = h_s - ONE;
    base_idx   = ((kx_s & ~low_mask_s) << 1'b1) | (kx_s & low_mask_s);
    pair_idx   = base_idx | h_s;
  end

endmodule

// File: rtl/fft2d_bfly_sched.sv
// Stage-by-stage quad issue controller for the in-place 2-D radix-2x2 FFT,
// with a write-back delay line aligned to the butterfly output.
module fft2d_bfly_sched
  import fft2d_bfly_sched_pkg::*;
#(
  parameter int unsigned LOG2N  = LOG2N_DEF,
  parameter int unsigned ADDR_W = 2 * LOG2N,
  parameter int unsigned RD_LAT = RD_LAT_DEF,
  parameter int unsigned BF_LAT = BF_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [LOG2N-1:0]  stage,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_1_1,
  output logic [ADDR_W-1:0] rd_addr_1_2,
  output logic [ADDR_W-1:0] rd_addr_2_1,
  output logic [ADDR_W-1:0] rd_addr_2_2,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_1_1,
  output logic [ADDR_W-1:0] wr_addr_1_2,
  output logic [ADDR_W-1:0] wr_addr_2_1,
  output logic [ADDR_W-1:0] wr_addr_2_2
);

  // For LOG2N=1 the quad counters collapse to a single always-zero bit.
  localparam int unsigned KW     = (LOG2N > 1) ? (LOG2N - 1) : 1;
  localparam int unsigned DLY    = RD_LAT + BF_LAT;
  localparam int unsigned DCW    = cnt_w(DLY);
  localparam int unsigned LINE_W = 4 * ADDR_W + 1;

  localparam logic [KW-1:0]    QMAX       = KW'((32'd1 << (LOG2N - 1)) - 32'd1);
  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);
  localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(DLY - 1);

  sched_state_e     state_r, state_n_s;
  logic [LOG2N-1:0] stage_r, stage_n_s;
  logic [KW-1:0]    kr_r, kr_n_s;
  logic [KW-1:0]    kc_r, kc_n_s;
  logic [DCW-1:0]   drain_r, drain_n_s;
  logic [LINE_W-1:0] line_r [DLY];

  logic             issue_s;
  logic [LOG2N-1:0] r_base_s, r_pair_s, c_base_s, c_pair_s;
  logic [ADDR_W-1:0] a11_s, a12_s, a21_s, a22_s;

  fft2d_pair_addr #(.LOG2N(LOG2N), .KW(KW)) u_row (
    .k        (kr_r),
    .s        (stage_r),
    .base_idx (r_base_s),
    .pair_idx (r_pair_s)
  );

  fft2d_pair_addr #(.LOG2N(LOG2N), .KW(KW)) u_col (
    .k        (kc_r),
    .s        (stage_r),
    .base_idx (c_base_s),
    .pair_idx (c_pair_s)
  );

  // FSM and counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      stage_r <= {LOG2N{1'b0}};
      kr_r    <= {KW{1'b0}};
      kc_r    <= {KW{1'b0}};
      drain_r <= {DCW{1'b0}};
    end else begin
      state_r <= state_n_s;
      stage_r <= stage_n_s;
      kr_r    <= kr_n_s;
      kc_r    <= kc_n_s;
      drain_r <= drain_n_s;
    end
  end

  // Next-state: quad walk with kc innermost, fixed-length drain between stages.
  always_comb begin
    state_n_s = state_r;
    stage_n_s = stage_r;
    kr_n_s    = kr_r;
    kc_n_s    = kc_r;
    drain_n_s = drain_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n_s = ST_ISSUE;
          stage_n_s = {LOG2N{1'b0}};
          kr_n_s    = {KW{1'b0}};
          kc_n_s    = {KW{1'b0}};
          drain_n_s = {DCW{1'b0}};
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!hold) begin
          if (kc_r == QMAX) begin
            kc_n_s = {KW{1'b0}};
            if (kr_r == QMAX) begin
              kr_n_s    = {KW{1'b0}};
              drain_n_s = {DCW{1'b0}};
              state_n_s = ST_DRAIN;
            end else begin
              kr_n_s = kr_r + 1'b1;
            end
          end else begin
            kc_n_s = kc_r + 1'b1;
          end
        end else begin
          state_n_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          drain_n_s = {DCW{1'b0}};
          if (stage_r == LAST_STAGE) begin
            state_n_s = ST_DONE;
          end else begin
            state_n_s = ST_ISSUE;
            stage_n_s = stage_r + 1'b1;
          end
        end else begin
          drain_n_s = drain_r + 1'b1;
        end
      end
      ST_DONE: begin
        state_n_s = ST_IDLE;
        stage_n_s = {LOG2N{1'b0}};
      end
      default: begin
        state_n_s = ST_IDLE;
        stage_n_s = {LOG2N{1'b0}};
        kr_n_s    = {KW{1'b0}};
        kc_n_s    = {KW{1'b0}};
        drain_n_s = {DCW{1'b0}};
      end
    endcase
  end

  // Read strobe and corner addresses; addresses held at zero when not issuing.
  always_comb begin
    issue_s = 1'b0;
    a11_s   = {ADDR_W{1'b0}};
    a12_s   = {ADDR_W{1'b0}};
    a21_s   = {ADDR_W{1'b0}};
    a22_s   = {ADDR_W{1'b0}};
    if ((state_r == ST_ISSUE) && !hold) begin
      issue_s = 1'b1;
      a11_s   = {r_base_s, c_base_s};
      a12_s   = {r_base_s, c_pair_s};
      a21_s   = {r_pair_s, c_base_s};
      a22_s   = {r_pair_s, c_pair_s};
    end else begin
      issue_s = 1'b0;
    end
  end

  // Write-back delay line: the issued quad reappears RD_LAT+BF_LAT cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) begin
        line_r[i] <= {LINE_W{1'b0}};
      end
    end else begin
      line_r[0] <= {issue_s, a11_s, a12_s, a21_s, a22_s};
      for (int i = 1; i < DLY; i++) begin
        line_r[i] <= line_r[i-1];
      end
    end
  end

  assign busy        = (state_r == ST_ISSUE) || (state_r == ST_DRAIN);
  assign done        = (state_r == ST_DONE);
  assign stage       = stage_r;
  assign rd_en       = issue_s;
  assign rd_addr_1_1 = a11_s;
  assign rd_addr_1_2 = a12_s;
  assign rd_addr_2_1 = a21_s;
  assign rd_addr_2_2 = a22_s;
  assign {wr_en, wr_addr_1_1, wr_addr_1_2, wr_addr_2_1, wr_addr_2_2} = line_r[DLY-1];

endmodule

// File: tb/tb_fft2d_bfly_sched.sv
// Directed bench for fft2d_bfly_sched: LOG2N=1 and LOG2N=3 instances, with a
// behavioural frame memory and 2x2 butterfly driven by the scheduler strobes.
module tb_fft2d_bfly_sched;

  logic clk = 1'b0;
  logic rst, start, hold, start1, hold1;

  logic       busy, done, rd_en, wr_en;
  logic [2:0] stage;
  logic [5:0] ra11, ra12, ra21, ra22, wa11, wa12, wa21, wa22;

  logic       busy1, done1, rd_en1, wr_en1;
  logic [0:0] stage1;
  logic [1:0] rb11, rb12, rb21, rb22, wb11, wb12, wb21, wb22;

  int n_checks = 0;
  int n_err    = 0;

  int mem [64];
  int wcnt [8][64];
  int bq [$];
  logic got2;
  logic [5:0] s2_a [4];

  always #5 clk = ~clk;

  fft2d_bfly_sched #(.LOG2N(3), .RD_LAT(1), .BF_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .busy(busy), .done(done), .stage(stage), .rd_en(rd_en),
    .rd_addr_1_1(ra11), .rd_addr_1_2(ra12), .rd_addr_2_1(ra21), .rd_addr_2_2(ra22),
    .wr_en(wr_en),
    .wr_addr_1_1(wa11), .wr_addr_1_2(wa12), .wr_addr_2_1(wa21), .wr_addr_2_2(wa22)
  );

  fft2d_bfly_sched #(.LOG2N(1), .RD_LAT(1), .BF_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .hold(hold1),
    .busy(busy1), .done(done1), .stage(stage1), .rd_en(rd_en1),
    .rd_addr_1_1(rb11), .rd_addr_1_2(rb12), .rd_addr_2_1(rb21), .rd_addr_2_2(rb22),
    .wr_en(wr_en1),
    .wr_addr_1_1(wb11), .wr_addr_1_2(wb12), .wr_addr_2_1(wb21), .wr_addr_2_2(wb22)
  );

  // Behavioural memory + twiddle-free butterfly, plus per-stage write tally.
  always @(negedge clk) begin
    if (rst) begin
      bq.delete();
    end else begin
      if (wr_en) begin
        mem[wa11] = bq.pop_front();
        mem[wa12] = bq.pop_front();
        mem[wa21] = bq.pop_front();
        mem[wa22] = bq.pop_front();
        wcnt[stage][wa11]++;
        wcnt[stage][wa12]++;
        wcnt[stage][wa21]++;
        wcnt[stage][wa22]++;
      end
      if (rd_en) begin
        bq.push_back(mem[ra11] + mem[ra12] + mem[ra21] + mem[ra22]);
        bq.push_back(mem[ra11] - mem[ra12] + mem[ra21] - mem[ra22]);
        bq.push_back(mem[ra11] + mem[ra12] - mem[ra21] - mem[ra22]);
        bq.push_back(mem[ra11] - mem[ra12] - mem[ra21] + mem[ra22]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pe();
    @(posedge clk);
    #1;
  endtask

  task automatic ne();
    @(negedge clk);
  endtask

  task automatic clear_tally();
    for (int s = 0; s < 8; s++) begin
      for (int a = 0; a < 64; a++) begin
        wcnt[s][a] = 0;
      end
    end
  endtask

  // One frame on the LOG2N=3 instance; k counts cycles after the start edge.
  task automatic run_frame(input int hold_at, input int rst_at,
                           output int busy_cnt, output int done_at);
    busy_cnt = 0;
    done_at  = 0;
    got2     = 1'b0;
    pe();
    start = 1'b1;
    pe();
    start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      ne();
      if (busy) busy_cnt++;
      if (done && done_at == 0) done_at = k;
      if (k == 1) begin
        chk("q0_a11", ra11, 0);  chk("q0_a12", ra12, 4);
        chk("q0_a21", ra21, 32); chk("q0_a22", ra22, 36);
        chk("q0_rd_en", rd_en, 1);
      end
      if (k == 2) begin
        chk("q1_a11", ra11, 1);  chk("q1_a12", ra12, 5);
        chk("q1_a21", ra21, 33); chk("q1_a22", ra22, 37);
      end
      if (stage == 3'd2 && rd_en && !got2) begin
        got2 = 1'b1;
        s2_a[0] = ra11; s2_a[1] = ra12; s2_a[2] = ra21; s2_a[3] = ra22;
      end
      if (hold_at > 0 && k >= hold_at && k < hold_at + 3) chk("hold_rd_en", rd_en, 0);
      if (hold_at > 0 && k == hold_at) chk("hold_wr_inflight", wr_en, 1);
      if (hold_at > 0 && k == hold_at + 2) chk("hold_wr_gap", wr_en, 0);
      if (hold_at > 0 && k == hold_at + 3) begin
        chk("resume_rd_en", rd_en, 1);
        chk("resume_a11", ra11, 9);
        chk("resume_a22", ra22, 27);
      end
      if (k == rst_at) begin
        chk("pre_rst_stage", stage, 1);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_wr_en", wr_en, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_wr_en", wr_en, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_stage", stage, 0);
        chk("async_rst_rd_en", rd_en, 0);
        break;
      end
      if (done_at != 0) break;
      pe();
      start = (k == 10 || k == 30);
      hold  = (hold_at > 0 && (k + 1) >= hold_at && (k + 1) < hold_at + 3);
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  int bc, da, bad;

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; start1 = 1'b0; hold1 = 1'b0;
    repeat (3) pe();
    ne();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stage", stage, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_a12", ra12, 0);
    chk("rst_wr_a22", wa22, 0);
    chk("rst_busy1", busy1, 0);
    pe();
    rst = 1'b0;
    pe();

    // LOG2N=1: single quad 0,1,2,3, write two cycles later, done after drain.
    start1 = 1'b1;
    pe();
    start1 = 1'b0;
    ne();
    chk("n2_rd_en", rd_en1, 1); chk("n2_busy", busy1, 1);
    chk("n2_rd_a11", rb11, 0); chk("n2_rd_a12", rb12, 1);
    chk("n2_rd_a21", rb21, 2); chk("n2_rd_a22", rb22, 3);
    pe(); ne();
    chk("n2_rd_en_t2", rd_en1, 0); chk("n2_wr_en_t2", wr_en1, 0); chk("n2_busy_t2", busy1, 1);
    pe(); ne();
    chk("n2_wr_en", wr_en1, 1); chk("n2_busy_t3", busy1, 1);
    chk("n2_wr_a11", wb11, 0); chk("n2_wr_a12", wb12, 1);
    chk("n2_wr_a21", wb21, 2); chk("n2_wr_a22", wb22, 3);
    pe(); ne();
    chk("n2_done", done1, 1); chk("n2_busy_t4", busy1, 0);
    pe(); ne();
    chk("n2_done_t5", done1, 0);

    // LOG2N=3 impulse at (0,0) -> all-ones frame; stray start pulses ignored.
    for (int a = 0; a < 64; a++) mem[a] = 0;
    mem[0] = 1;
    clear_tally();
    run_frame(0, 0, bc, da);
    chk("imp_busy_cycles", bc, 54);
    chk("imp_done_at", da, 55);
    chk("s2_a11", s2_a[0], 0); chk("s2_a12", s2_a[1], 1);
    chk("s2_a21", s2_a[2], 8); chk("s2_a22", s2_a[3], 9);
    bad = 0;
    for (int a = 0; a < 64; a++) if (mem[a] != 1) bad++;
    chk("imp_not_one", bad, 0);
    bad = 0;
    for (int s = 0; s < 8; s++)
      for (int a = 0; a < 64; a++)
        if (wcnt[s][a] != ((s < 3) ? 1 : 0)) bad++;
    chk("write_once_per_stage", bad, 0);
    pe(); ne();
    chk("post_done_pulse", done, 0);
    chk("post_busy", busy, 0);

    // Constant frame with a 3-cycle hold in stage 1 -> N^2 at (0,0).
    for (int a = 0; a < 64; a++) mem[a] = 1;
    run_frame(24, 0, bc, da);
    chk("hold_busy_cycles", bc, 57);
    chk("hold_done_at", da, 58);
    chk("dc_value", mem[0], 64);
    bad = 0;
    for (int a = 1; a < 64; a++) if (mem[a] != 0) bad++;
    chk("dc_nonzero", bad, 0);

    // Reset during stage 1 drain, then a clean full frame from stage 0.
    run_frame(0, 35, bc, da);
    pe(); pe();
    rst = 1'b0;
    pe();
    ne();
    chk("after_rst_busy", busy, 0);
    run_frame(0, 0, bc, da);
    chk("rerun_busy_cycles", bc, 54);
    chk("rerun_done_at", da, 55);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
